// File: rtl/burst_mem_responder_pkg.sv
// Shared pmem line-burst types for the burst memory responder.
// Beat/line shapes and the responder FSM state encoding.
package pmem_types;

    localparam int PMEM_BEATS         = 4;
    localparam int PMEM_LINE_OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        RECOVER
    } bmr_state_e;

    typedef logic [63:0]                beat_t;
    typedef beat_t [PMEM_BEATS-1:0]     line_t;

endpackage

// File: rtl/burst_mem_responder_if.sv
// pmem line-burst bus between the cacheline adaptor and memory.
// master drives requests/write beats; slave returns resp/read beats.
interface burst_mem_responder_if #(
    parameter int DATA_W = 64
);
    logic              read_i;
    logic              write_i;
    logic [31:0]       address_i;
    logic [DATA_W-1:0] burst_i;
    logic [DATA_W-1:0] burst_o;
    logic              resp_o;
    logic              error_o;

    modport master (
        output read_i, write_i, address_i, burst_i,
        input  burst_o, resp_o, error_o
    );

    modport slave (
        input  read_i, write_i, address_i, burst_i,
        output burst_o, resp_o, error_o
    );
endinterface

// File: rtl/burst_mem_responder_array.sv
// Line storage for the responder: DEPTH_LINES x BEATS beats,
// registered read, full-beat write, storage itself never reset.
module burst_mem_array
    import pmem_types::*;
#(
    parameter int DEPTH_LINES = 256,
    parameter int BEATS       = PMEM_BEATS,
    parameter int DATA_W      = 64,
    parameter int LINE_W      = $clog2(DEPTH_LINES),
    parameter int BEAT_W      = $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [LINE_W-1:0] line,
    input  logic [BEAT_W-1:0] beat,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH_LINES][BEATS];

    // beat write; contents survive reset
    always_ff @(posedge clk) begin
        if (we) mem[line][beat] <= wdata;
    end

    // read register only updates on a read so the last beat is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[line][beat];
    end
endmodule

// File: rtl/burst_mem_responder.sv
// pmem responder: IDLE -> WAIT(latency) -> BURST(beats) -> RECOVER.
// Optional protocol checker enabled by defining BMR_ERR_CHECK_EN.
module burst_mem_responder
    import pmem_types::*;
#(
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 8,
    parameter int BEATS       = PMEM_BEATS,
    parameter int DATA_W      = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    burst_mem_responder_if.slave  bus
);
    localparam int LINE_W = $clog2(DEPTH_LINES);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    bmr_state_e        state, nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] mem_beat;
    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_in;
    logic              op_rd;
    logic              start;
    logic              req;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] rdata;

    assign start   = bus.read_i | bus.write_i;
    assign req     = op_rd ? bus.read_i : bus.write_i;
    assign line_in = bus.address_i[PMEM_LINE_OFFSET_W +: LINE_W];

    // next state and array strobes; reads are issued one cycle ahead
    always_comb begin
        nxt      = state;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        mem_beat = beat_cnt;
        unique case (state)
            IDLE: begin
                if (start) nxt = WAIT;
            end
            WAIT: begin
                if (!req) begin
                    nxt = IDLE;
                end else if (wait_cnt == '0) begin
                    nxt      = BURST;
                    mem_re   = op_rd;
                    mem_beat = '0;
                end
            end
            BURST: begin
                if (!req) begin
                    nxt = IDLE;
                end else begin
                    mem_we = ~op_rd;
                    if (beat_cnt == BEAT_W'(BEATS-1)) begin
                        nxt = RECOVER;
                    end else if (op_rd) begin
                        mem_re   = 1'b1;
                        mem_beat = beat_cnt + 1'b1;
                    end
                end
            end
            RECOVER: begin
                nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // state, latched op/line, latency and beat counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            beat_cnt <= '0;
            op_rd    <= 1'b0;
            line_q   <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && start) begin
                op_rd    <= bus.read_i;
                line_q   <= line_in;
                wait_cnt <= CNT_W'(LATENCY-1);
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (state == BURST && nxt == BURST) beat_cnt <= beat_cnt + 1'b1;
            else                                beat_cnt <= '0;
        end
    end

    burst_mem_array #(
        .DEPTH_LINES (DEPTH_LINES),
        .BEATS       (BEATS),
        .DATA_W      (DATA_W)
    ) u_array (
        .clk   (clk),
        .rst_n (reset_n),
        .we    (mem_we),
        .re    (mem_re),
        .line  (line_q),
        .beat  (mem_beat),
        .wdata (bus.burst_i),
        .rdata (rdata)
    );

    assign bus.resp_o  = (state == BURST);
    assign bus.burst_o = rdata;

`ifdef BMR_ERR_CHECK_EN
    logic [31:0] addr_q;
    logic        error_q;
    logic        err_hit;

    // any protocol violation visible this cycle
    always_comb begin
        err_hit = bus.read_i & bus.write_i;
        if (state == IDLE && start &&
            bus.address_i[PMEM_LINE_OFFSET_W-1:0] != '0)
            err_hit = 1'b1;
        if ((state == WAIT || state == BURST) &&
            (!req || bus.address_i != addr_q))
            err_hit = 1'b1;
    end

    // sticky error flag and the address it is compared against
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            error_q <= 1'b0;
        end else begin
            if (state == IDLE && start) addr_q <= bus.address_i;
            error_q <= error_q | err_hit;
        end
    end

    assign bus.error_o = error_q;
`else
    logic unused_addr;
    assign unused_addr = ^{bus.address_i[31:PMEM_LINE_OFFSET_W+LINE_W],
                           bus.address_i[PMEM_LINE_OFFSET_W-1:0]};
    assign bus.error_o = 1'b0;
`endif
endmodule

// File: tb/tb_burst_mem_responder.sv
// Random-stimulus bench for burst_mem_responder with a cycle-level
// behavioural model (edge-scheduled beats, line-array memory image).
module tb_burst_mem_responder;
    import pmem_types::*;

    localparam int L     = 8;
    localparam int DEPTH = 256;
    localparam int NB    = 4;
`ifdef BMR_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    burst_mem_responder_if #(.DATA_W(64)) bus ();

    burst_mem_responder #(
        .DEPTH_LINES (DEPTH),
        .LATENCY     (L),
        .BEATS       (NB),
        .DATA_W      (64)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    edge_no;
        beat_t data;
        bit    rd;
    } exp_t;

    exp_t  expq[$];
    beat_t model_mem [DEPTH][NB];
    beat_t last_rd = '0;
    bit    exp_err = 1'b0;
    int    err_edge = -1;
    int    cyc = 0;
    int    ready_edge = 0;
    int    checks = 0;
    int    errors = 0;
    int    last_rise = -1;
    int    resp_count = 0;
    logic  prev_resp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h",
                     name, cyc, act, expv);
        end
    endtask

    // edge counter plus the error-flag model (driven inputs are stable here)
    always @(posedge clk) begin
        cyc++;
        if (reset_n && ERR_EN) begin
            if (bus.read_i && bus.write_i) exp_err = 1'b1;
            if (cyc == err_edge) exp_err = 1'b1;
        end
    end

    // single compare process: every cycle out of reset
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.resp_o === 1'b1 && prev_resp !== 1'b1) last_rise = cyc;
            if (bus.resp_o === 1'b1) resp_count++;
            prev_resp = bus.resp_o;
            if (expq.size() > 0 && expq[0].edge_no == cyc) begin
                chk("resp_beat", 64'(bus.resp_o), 64'd1);
                if (expq[0].rd) begin
                    chk("read_data", bus.burst_o, expq[0].data);
                    last_rd = expq[0].data;
                end
                void'(expq.pop_front());
            end else begin
                chk("resp_quiet", 64'(bus.resp_o), 64'd0);
                chk("burst_hold", bus.burst_o, last_rd);
            end
            chk("error_flag", 64'(bus.error_o), 64'(exp_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // full line transaction; abort >= 0 pulses reset during that beat
    task automatic txn(input bit rd, input bit both,
                       input logic [31:0] addr, input line_t wd,
                       input int abort);
        int   s;
        int   ln;
        bit   rdop;
        exp_t e;
        rdop = rd | both;
        ln = int'(addr[12:5]) % DEPTH;
        bus.address_i = addr;
        bus.read_i    = rdop;
        bus.write_i   = ~rd | both;
        s = (cyc + 1 > ready_edge) ? cyc + 1 : ready_edge;
        for (int b = 0; b < NB; b++) begin
            e.edge_no = s + L + b;
            e.rd      = rdop;
            e.data    = rdop ? model_mem[ln][b] : wd[b];
            expq.push_back(e);
            if (!rdop) model_mem[ln][b] = wd[b];
        end
        while (cyc < s + L + 4) begin
            if (cyc >= s + L && cyc < s + L + 4) bus.burst_i = wd[cyc-s-L];
            else bus.burst_i = {$urandom, $urandom};
            if (abort >= 0 && cyc == s + L + abort) begin
                #1 reset_n = 1'b0;
                #1;
                chk("reset_resp", 64'(bus.resp_o), 64'd0);
                chk("reset_burst", bus.burst_o, 64'd0);
                expq.delete();
                bus.read_i  = 1'b0;
                bus.write_i = 1'b0;
                step();
                step();
                reset_n    = 1'b1;
                exp_err    = 1'b0;
                last_rd    = '0;
                prev_resp  = 1'b0;
                ready_edge = cyc + 1;
                return;
            end
            step();
        end
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        ready_edge  = s + L + 6;
    endtask

    // request withdrawn while the responder is still waiting
    task automatic wait_drop(input logic [31:0] addr, input int hold);
        bus.address_i = addr;
        bus.read_i    = 1'b1;
        for (int i = 0; i < hold; i++) step();
        bus.read_i = 1'b0;
        err_edge   = cyc + 1;
        ready_edge = cyc + 2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        line_t d, a, bb, w;
        int    c0;
        int    n0;
        int    ln;
        logic [31:0] ad;

        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.address_i = '0;
        bus.burst_i   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int b = 0; b < NB; b++) begin
                model_mem[i][b] = {$urandom, $urandom};
                dut.u_array.mem[i][b] = model_mem[i][b];
            end
        end
        d = {64'hd3d3_0000_0000_0003, 64'hd2d2_0000_0000_0002,
             64'hd1d1_0000_0000_0001, 64'hd0d0_0000_0000_0000};
        for (int b = 0; b < NB; b++) begin
            model_mem[2][b] = d[b];
            dut.u_array.mem[2][b] = d[b];
        end

        step();
        step();
        chk("rst_resp", 64'(bus.resp_o), 64'd0);
        chk("rst_burst", bus.burst_o, 64'd0);
        chk("rst_error", 64'(bus.error_o), 64'd0);
        reset_n    = 1'b1;
        ready_edge = cyc + 1;
        step();

        // read line 0x40: beats 8..11 edges after sampling, D0..D3
        c0 = cyc;
        n0 = resp_count;
        txn(1'b1, 1'b0, 32'h40, '0, -1);
        step();
        step();
        chk("t1_latency", 64'(last_rise - (c0 + 1)), 64'd8);
        chk("t1_beats", 64'(resp_count - n0), 64'd4);
        chk("t1_last_beat", bus.burst_o, 64'hd3d3_0000_0000_0003);

        // write then read back 0x1000, backdoor at line 0x80
        a = {64'ha3, 64'ha2, 64'ha1, 64'ha0};
        txn(1'b0, 1'b0, 32'h1000, a, -1);
        step();
        txn(1'b1, 1'b0, 32'h1000, '0, -1);
        chk("t2_backdoor0", dut.u_array.mem[8'h80][0], 64'ha0);
        chk("t2_backdoor3", dut.u_array.mem[8'h80][3], 64'ha3);

        // wrap: 0x2000 aliases line 0
        bb = {64'hb3, 64'hb2, 64'hb1, 64'hb0};
        txn(1'b0, 1'b0, 32'h2000, bb, -1);
        step();
        txn(1'b1, 1'b0, 32'h0000, '0, -1);
        chk("t3_wrap_bd", dut.u_array.mem[0][2], 64'hb2);

        // reset during beat 2, then full-latency reread
        step();
        txn(1'b1, 1'b0, 32'h40, '0, 2);
        c0 = cyc;
        n0 = resp_count;
        txn(1'b1, 1'b0, 32'h40, '0, -1);
        step();
        chk("t4_latency", 64'(last_rise - (c0 + 1)), 64'd8);
        chk("t4_beats", 64'(resp_count - n0), 64'd4);

        // back-to-back: drop one cycle then reassert
        txn(1'b1, 1'b0, 32'h1000, '0, -1);
        step();
        n0 = resp_count;
        txn(1'b1, 1'b0, 32'h2000, '0, -1);
        step();
        step();
        chk("t5_beats", 64'(resp_count - n0), 64'd4);

        // randomized mix, gaps 0..3 (0 = request held through RECOVER)
        for (int t = 0; t < 24; t++) begin
            ln = $urandom_range(0, 7);
            ad = (32'($urandom_range(0, 3)) << 13) | (32'(ln) << 5);
            for (int b = 0; b < NB; b++) w[b] = {$urandom, $urandom};
            for (int g = $urandom_range(0, 3); g > 0; g--) step();
            txn(1'($urandom_range(0, 1)), 1'b0, ad, w, -1);
        end
        step();
        step();

        // both requests at unaligned 0x44: read served, error per build
        n0 = resp_count;
        txn(1'b1, 1'b1, 32'h44, '0, -1);
        step();
        step();
        chk("t6_beats", 64'(resp_count - n0), 64'd4);
        chk("t6_error", 64'(bus.error_o), 64'(ERR_EN));

        // request dropped in WAIT: no beats
        step();
        n0 = resp_count;
        wait_drop(32'h80, 3);
        for (int i = 0; i < L + 4; i++) step();
        chk("t7_no_beats", 64'(resp_count - n0), 64'd0);
        chk("t7_error", 64'(bus.error_o), 64'(ERR_EN));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
